// File: rtl/acc_out_fifo.sv
// Output FIFO behind the accumulator: first-word-fall-through, valid/ready drain, sticky overflow.
// Optional drop counter port enabled by defining ACC_OUT_FIFO_DROPCNT_EN.
module acc_out_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         wr_en,
    input  logic [DATA_W-1:0]            ext_in,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow
`ifdef ACC_OUT_FIFO_DROPCNT_EN
    ,
    output logic [7:0]                   drop_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_nxt;
    logic [LW-1:0]     level_nxt;
    logic              pop;
    logic              push;
    logic              drop;

    assign pop    = out_valid && out_ready;
    assign push   = wr_en && (!full || pop);
    assign drop   = wr_en && full && !pop;
    assign rd_nxt = rd_ptr + PW'(1);
    assign full   = (level == LW'(DEPTH));

    always_comb begin
        level_nxt = level;
        if (push && !pop)
            level_nxt = level + LW'(1);
        else if (pop && !push)
            level_nxt = level - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst && !clr && push)
            mem[wr_ptr] <= ext_in;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_nxt;
            level     <= level_nxt;
            out_valid <= (level_nxt != '0);
            if (drop)
                overflow <= 1'b1;
            // The head register tracks the slot at the read pointer; a new
            // entry bypasses memory when it becomes the head immediately.
            if (pop && level > LW'(1))
                out_data <= mem[rd_nxt];
            else if (push && (level == '0 || (pop && level == LW'(1))))
                out_data <= ext_in;
        end
    end

`ifdef ACC_OUT_FIFO_DROPCNT_EN
    always_ff @(posedge clk) begin
        if (rst || clr)
            drop_cnt <= '0;
        else if (drop && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end
`endif

    a_stable: assert property (@(posedge clk)
        (!rst && !clr && out_valid && !out_ready) |=> $stable(out_data));
    a_level: assert property (@(posedge clk) disable iff (rst)
        level <= LW'(DEPTH));
    a_full: assert property (@(posedge clk) disable iff (rst)
        full == (level == LW'(DEPTH)));

endmodule

// File: tb/tb_acc_out_fifo.sv
// Bench for acc_out_fifo: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_acc_out_fifo;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        wr_en;
    logic [15:0] ext_in;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        full;
    logic [2:0]  level;
    logic        overflow;
`ifdef ACC_OUT_FIFO_DROPCNT_EN
    logic [7:0]  drop_cnt;
`endif

    int          n_err;
    int          n_chk;
    logic [15:0] q[$];
    logic        m_ov;
    logic [15:0] m_od;
    int          m_drop;

    acc_out_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .wr_en     (wr_en),
        .ext_in    (ext_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .full      (full),
        .level     (level),
        .overflow  (overflow)
`ifdef ACC_OUT_FIFO_DROPCNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare();
        chk("valid", 32'(out_valid), 32'(q.size() != 0));
        chk("level", 32'(level), q.size());
        chk("full", 32'(full), 32'(q.size() == 4));
        chk("ovf", 32'(overflow), 32'(m_ov));
        chk("data", 32'(out_data), 32'(m_od));
`ifdef ACC_OUT_FIFO_DROPCNT_EN
        chk("dropcnt", 32'(drop_cnt), m_drop);
`endif
    endtask

    // Drive one cycle at the falling edge, advance the model, check after the edge.
    task automatic cyc(input logic r, input logic c, input logic w,
                       input logic [15:0] d, input logic rdy);
        int n;
        bit p;
        bit pu;
        rst = r; clr = c; wr_en = w; ext_in = d; out_ready = rdy;
        if (r || c) begin
            q.delete();
            m_ov = 0;
            m_od = '0;
            m_drop = 0;
        end else begin
            n  = q.size();
            p  = (n > 0) && rdy;
            pu = w && (n < 4 || p);
            if (p) void'(q.pop_front());
            if (pu) q.push_back(d);
            if (w && !pu) begin
                m_ov = 1;
                if (m_drop < 255) m_drop++;
            end
            if (q.size() > 0) m_od = q[0];
        end
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    initial begin
        logic [15:0] exp3 [3];
        n_err = 0; n_chk = 0;
        clk = 0; rst = 1; clr = 0; wr_en = 0; ext_in = '0; out_ready = 0;
        m_ov = 0; m_od = '0; m_drop = 0;
        @(negedge clk);
        cyc(1, 0, 0, 16'h0, 0);
        cyc(1, 0, 0, 16'h0, 0);
        chk("rst_lvl", 32'(level), 0);
        chk("rst_val", 32'(out_valid), 0);

        // reset during activity
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 16'h0050 + 16'(i), 0);
        cyc(1, 0, 1, 16'h0077, 1);
        chk("ra_lvl", 32'(level), 0);
        chk("ra_dat", 32'(out_data), 0);
        cyc(0, 0, 1, 16'h0011, 0);
        chk("ra_push", 32'(out_data), 32'h0011);

        // basic order
        cyc(0, 1, 0, 16'h0, 0);
        exp3[0] = 16'h1234; exp3[1] = 16'h8001; exp3[2] = 16'h7FFF;
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, exp3[i], 0);
        chk("bo_lvl", 32'(level), 3);
        cyc(0, 0, 0, 16'h0, 0);
        chk("bo_hold", 32'(out_data), 32'h1234);
        for (int i = 0; i < 3; i++) begin
            chk("bo_out", 32'(out_data), 32'(exp3[i]));
            cyc(0, 0, 0, 16'h0, 1);
        end
        chk("bo_empty", 32'(out_valid), 0);

        // full + overflow
        cyc(0, 1, 0, 16'h0, 0);
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 0, 1, 16'(i), 0);
            if (i == 4) chk("fo_full", 32'(full), 1);
        end
        chk("fo_ovf", 32'(overflow), 1);
        chk("fo_lvl", 32'(level), 4);
        for (int i = 1; i <= 4; i++) begin
            chk("fo_out", 32'(out_data), i);
            cyc(0, 0, 0, 16'h0, 1);
        end
        chk("fo_empty", 32'(out_valid), 0);

        // push + pop at full
        cyc(0, 1, 0, 16'h0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 16'h00A0 + 16'(i), 0);
        cyc(0, 0, 1, 16'h00B0, 1);
        chk("pp_lvl", 32'(level), 4);
        chk("pp_ovf", 32'(overflow), 0);
        exp3[0] = 16'h00A1; exp3[1] = 16'h00A2; exp3[2] = 16'h00A3;
        for (int i = 0; i < 3; i++) begin
            chk("pp_out", 32'(out_data), 32'(exp3[i]));
            cyc(0, 0, 0, 16'h0, 1);
        end
        chk("pp_last", 32'(out_data), 32'h00B0);
        cyc(0, 0, 0, 16'h0, 1);

        // wrap-around streaming
        cyc(0, 1, 0, 16'h0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1, 16'h0100 + 16'(i), 1);
            chk("wr_dat", 32'(out_data), 32'h0100 + i);
            chk("wr_lvl", 32'(level), 1);
        end

        // clr mid-stream
        cyc(0, 1, 0, 16'h0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 16'h0030 + 16'(i), 0);
        cyc(0, 0, 0, 16'h0, 1);
        cyc(0, 0, 0, 16'h0, 1);
        chk("cl_pre", 32'(level), 2);
        chk("cl_ovf", 32'(overflow), 1);
        cyc(0, 1, 1, 16'hDEAD, 0);
        chk("cl_lvl", 32'(level), 0);
        chk("cl_ovf0", 32'(overflow), 0);
        chk("cl_val", 32'(out_valid), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 16'h0, 1);
            chk("cl_dead", 32'(out_data == 16'hDEAD), 0);
        end

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0),
                ($urandom_range(0, 99) < 60), 16'($urandom),
                ($urandom_range(0, 99) < 45));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
